mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, giving the maximum cycles a read waits for av_readdatavalid.
REQ-002 clk_sys  in  1  sole clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 a_addr  in  32  requester A (HPS DMA) byte address, sampled on the a_rd/a_wr pulse.
REQ-005 a_din  in  32  requester A write data, sampled on the a_wr pulse.
REQ-006 a_rd, a_wr  in  1 each  requester A single-cycle read/write request pulses.
REQ-007 a_dout  out  32  requester A read data.
REQ-008 a_wait  out  1  requester A transaction pending.
REQ-009 b_addr, b_din, b_rd, b_wr, b_dout, b_wait  same widths/meanings as A  requester B (loader).
REQ-010 b_be  in  4  requester B byte enables, sampled on the b_wr pulse.
REQ-011 av_address  out  32  Avalon-MM master address.
REQ-012 av_read, av_write  out  1 each  Avalon-MM master commands.
REQ-013 av_writedata  out  32  Avalon-MM write data.
REQ-014 av_byteenable  out  4  Avalon-MM byte enables.
REQ-015 av_waitrequest  in  1  Avalon-MM slave stall.
REQ-016 av_readdata  in  32  Avalon-MM read data.
REQ-017 av_readdatavalid  in  1  Avalon-MM read data valid.
REQ-018 timeout_err  out  1  sticky flag, set when any read times out.

Function
REQ-019 A request pulse SHALL latch address, data and byte enables into that requester's slot, set its pending bit, and assert its x_wait on the next cycle.
REQ-020 A pulse arriving while that requester's slot is pending SHALL be ignored.
REQ-021 If x_rd and x_wr are both high in the same cycle, the write SHALL be taken and the read dropped.
REQ-022 Requester A byte enables SHALL always be 4'b1111.
REQ-023 The state machine SHALL have states IDLE, CMD and RDWAIT, with one outstanding transaction at most.
REQ-024 In IDLE, if any slot is pending, the block SHALL grant a requester and enter CMD on the next edge.
REQ-025 When both slots are pending, the grant SHALL go to the requester not served last (round-robin).
REQ-026 In CMD, av_read or av_write and the slot's address, data and byte enables SHALL be driven and held stable while av_waitrequest=1.
REQ-027 On an edge in CMD with av_waitrequest=0, a write SHALL clear the slot's pending bit and x_wait and return to IDLE.
REQ-028 On an edge in CMD with av_waitrequest=0, a read SHALL drop av_read and enter RDWAIT.
REQ-029 In RDWAIT, av_readdatavalid=1 SHALL load av_readdata into x_dout, clear pending and x_wait, and return to IDLE.
REQ-030 In RDWAIT, a 8-bit cycle counter SHALL start at 0; reaching TIMEOUT with no av_readdatavalid SHALL load x_dout=32'hFFFFFFFF, set timeout_err, complete the read, and return to IDLE.
REQ-031 av_readdatavalid outside RDWAIT SHALL be ignored.
REQ-032 The minimum latency from request pulse to x_wait low SHALL be 3 cycles for a write and 4 cycles for a read, with av_waitrequest=0 and readdatavalid arriving 1 cycle after the command.
REQ-033 A new request from the just-served requester SHALL be acceptable in the same cycle its x_wait falls.
REQ-034 x_dout SHALL hold its value until that requester's next read completes.

Reset
REQ-035 On reset=1 at an edge, the block SHALL set state=IDLE, clear pending bits, set last-served=B (A wins the first tie), and clear the counter.
REQ-036 On reset=1 at an edge, all outputs SHALL be 0, including timeout_err and x_dout.
REQ-037 Reset mid-transaction SHALL abandon the transaction, and a late av_readdatavalid SHALL be ignored.

Verification
REQ-038 Write scenario: a_wr with addr 0x100 and din 0xDEADBEEF, av_waitrequest=1 for 3 cycles. Required: av_write held with stable address and data for 4 cycles, then a_wait falls.
REQ-039 Read scenario: b_rd with addr 0x200, readdatavalid 5 cycles after acceptance with data 0x12345678. Required: b_dout=0x12345678 and b_wait falls the next cycle.
REQ-040 Tie scenario: a_rd and b_rd in the same cycle, then both again. Required: grant order A, B, A, B.
REQ-041 Timeout scenario: a_rd with no readdatavalid for TIMEOUT cycles. Required: a_dout=0xFFFFFFFF, timeout_err=1, a_wait=0.
REQ-042 Conflict scenario: a_rd and a_wr in the same cycle. Required: only av_write issued. Also: a_wr while a_wait=1 is ignored.
REQ-043 Reset scenario: reset asserted while in RDWAIT, then readdatavalid. Required: all outputs 0, state IDLE, no data captured.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle for the two-requester memory arbiter.
// Modports are named from the requester side: "master" is the environment
// (requesters plus the Avalon slave), "slave" is the arbiter itself.
interface mem_arbiter_if;
  // requester A (HPS DMA)
  logic [31:0] a_addr;
  logic [31:0] a_din;
  logic        a_rd;
  logic        a_wr;
  logic [31:0] a_dout;
  logic        a_wait;
  // requester B (loader)
  logic [31:0] b_addr;
  logic [31:0] b_din;
  logic [3:0]  b_be;
  logic        b_rd;
  logic        b_wr;
  logic [31:0] b_dout;
  logic        b_wait;
  // Avalon-MM master side
  logic [31:0] av_address;
  logic        av_read;
  logic        av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic        av_waitrequest;
  logic [31:0] av_readdata;
  logic        av_readdatavalid;
  // status
  logic        timeout_err;

  modport slave (
    input  a_addr, a_din, a_rd, a_wr,
    input  b_addr, b_din, b_be, b_rd, b_wr,
    input  av_waitrequest, av_readdata, av_readdatavalid,
    output a_dout, a_wait, b_dout, b_wait,
    output av_address, av_read, av_write, av_writedata, av_byteenable,
    output timeout_err
  );

  modport master (
    output a_addr, a_din, a_rd, a_wr,
    output b_addr, b_din, b_be, b_rd, b_wr,
    output av_waitrequest, av_readdata, av_readdatavalid,
    input  a_dout, a_wait, b_dout, b_wait,
    input  av_address, av_read, av_write, av_writedata, av_byteenable,
    input  timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter onto a single Avalon-MM master port.
// Each requester owns one slot; one Avalon transaction is outstanding at most.
// Index 0 is requester A, index 1 is requester B throughout.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input logic        clk_sys,
  input logic        reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CMD, RDWAIT} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        wr;
  } slot_t;

  // compare in 9 bits so TIMEOUT=0 degrades to a one-cycle wait instead of wrapping
  localparam logic [8:0] TO9 = 9'(TIMEOUT);

  state_t            state_q, state_d;
  slot_t [1:0]       slot_q, slot_d;
  logic  [1:0]       pend_q, pend_d;
  logic              last_q, last_d;   // requester served most recently
  logic              gnt_q, gnt_d;     // requester owning the current transaction
  logic  [7:0]       cnt_q, cnt_d;
  logic  [1:0][31:0] dout_q, dout_d;
  logic              terr_q, terr_d;

  logic  [1:0]       rd_i, wr_i;
  logic  [1:0][31:0] addr_i, din_i;
  logic  [1:0][3:0]  be_i;
  logic              nxt;
  slot_t             cur;

  assign rd_i   = {bus.b_rd, bus.a_rd};
  assign wr_i   = {bus.b_wr, bus.a_wr};
  assign addr_i = {bus.b_addr, bus.a_addr};
  assign din_i  = {bus.b_din, bus.a_din};
  assign be_i   = {bus.b_be, 4'hF};
  assign cur    = slot_q[gnt_q];

  // slot capture, grant and transaction sequencing
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    pend_d  = pend_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    terr_d  = terr_q;
    nxt     = 1'b0;

    // a busy slot ignores new pulses; write beats read on a simultaneous pulse
    for (int r = 0; r < 2; r++) begin
      if (!pend_q[r] && (rd_i[r] || wr_i[r])) begin
        pend_d[r]      = 1'b1;
        slot_d[r].addr = addr_i[r];
        slot_d[r].data = din_i[r];
        slot_d[r].be   = be_i[r];
        slot_d[r].wr   = wr_i[r];
      end
    end

    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          nxt     = (pend_q == 2'b11) ? ~last_q : pend_q[1];
          gnt_d   = nxt;
          last_d  = nxt;
          state_d = CMD;
        end
      end
      CMD: begin
        if (!bus.av_waitrequest) begin
          if (cur.wr) begin
            pend_d[gnt_q] = 1'b0;
            state_d       = IDLE;
          end else begin
            cnt_d   = 8'd0;
            state_d = RDWAIT;
          end
        end
      end
      RDWAIT: begin
        if (bus.av_readdatavalid) begin
          dout_d[gnt_q] = bus.av_readdata;
          pend_d[gnt_q] = 1'b0;
          state_d       = IDLE;
        end else if (({1'b0, cnt_q} + 9'd1) >= TO9) begin
          dout_d[gnt_q] = 32'hFFFF_FFFF;
          terr_d        = 1'b1;
          pend_d[gnt_q] = 1'b0;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers; reset abandons any transaction in flight
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
      pend_q  <= 2'b00;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      cnt_q   <= 8'd0;
      dout_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.av_read       = (state_q == CMD) && !cur.wr;
  assign bus.av_write      = (state_q == CMD) &&  cur.wr;
  assign bus.av_address    = (state_q == CMD) ? cur.addr : 32'd0;
  assign bus.av_writedata  = (state_q == CMD) ? cur.data : 32'd0;
  assign bus.av_byteenable = (state_q == CMD) ? cur.be   : 4'd0;
  assign bus.a_dout        = dout_q[0];
  assign bus.b_dout        = dout_q[1];
  assign bus.a_wait        = pend_q[0];
  assign bus.b_wait        = pend_q[1];
  assign bus.timeout_err   = terr_q;

endmodule
